// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a 2-entry skid buffer, flush and stall handling.
// Optional stall/bubble counters are enabled by defining PIPE_SKID_PERF_EN.
module pipe_stage_skid #(
  parameter int LANES = 2,
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES-1:0]       in_lane_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES-1:0]       out_lane_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   rdy_q, rdy_d;

  logic [LANES-1:0]       m_lv_q, m_lv_d;
  logic [LANES*WIDTH-1:0] m_dat_q, m_dat_d;
  logic [LANES-1:0]       s_lv_q, s_lv_d;
  logic [LANES*WIDTH-1:0] s_dat_q, s_dat_d;

  logic accept;
  logic pop;

  assign accept = in_valid & rdy_q;
  assign pop    = (state_q != EMPTY) & out_ready;

  always_comb begin
    state_d = state_q;
    m_lv_d  = m_lv_q;
    m_dat_d = m_dat_q;
    s_lv_d  = s_lv_q;
    s_dat_d = s_dat_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
          m_lv_d  = in_lane_valid;
          m_dat_d = in_data;
        end
      end
      FULL: begin
        if (accept && pop) begin
          m_lv_d  = in_lane_valid;
          m_dat_d = in_data;
        end else if (accept) begin
          state_d = SKID;
          s_lv_d  = in_lane_valid;
          s_dat_d = in_data;
        end else if (pop) begin
          state_d = EMPTY;
          m_lv_d  = '0;
          m_dat_d = '0;
        end
      end
      SKID: begin
        if (pop) begin
          state_d = FULL;
          m_lv_d  = s_lv_q;
          m_dat_d = s_dat_q;
          s_lv_d  = '0;
          s_dat_d = '0;
        end
      end
      default: begin
        state_d = EMPTY;
        m_lv_d  = '0;
        m_dat_d = '0;
        s_lv_d  = '0;
        s_dat_d = '0;
      end
    endcase
    // Flush drops both entries and whatever was offered this cycle.
    if (flush) begin
      state_d = EMPTY;
      m_lv_d  = '0;
      m_dat_d = '0;
      s_lv_d  = '0;
      s_dat_d = '0;
    end
    rdy_d = (state_d != SKID);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
      m_lv_q  <= '0;
      m_dat_q <= '0;
      s_lv_q  <= '0;
      s_dat_q <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      m_lv_q  <= m_lv_d;
      m_dat_q <= m_dat_d;
      s_lv_q  <= s_lv_d;
      s_dat_q <= s_dat_d;
    end
  end

  assign in_ready       = rdy_q;
  assign out_valid      = (state_q != EMPTY);
  assign out_lane_valid = m_lv_q;
  assign out_data       = m_dat_q;

`ifdef PIPE_SKID_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (out_valid && !out_ready && !(&stall_q))
      stall_d = stall_q + CNT_W'(1);
    if (!out_valid && out_ready && !(&bubble_q))
      bubble_d = bubble_q + CNT_W'(1);
  end

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: FIFO-level model plus directed literal checks.
// Counter expectations follow PIPE_SKID_PERF_EN when defined.
module tb_pipe_stage_skid;

  localparam int LANES = 2;
  localparam int WIDTH = 16;
  localparam int CNT_W = 4;
  localparam int DW    = LANES * WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [LANES-1:0] in_lane_valid = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [LANES-1:0] out_lane_valid;
  logic [DW-1:0] out_data;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] bubble_cnt;

  int errs = 0;
  int checks = 0;

  pipe_stage_skid #(
    .LANES(LANES),
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_lane_valid(in_lane_valid),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_lane_valid(out_lane_valid),
    .out_data(out_data),
    .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: an in-order queue of at most two groups.
  typedef logic [LANES+DW-1:0] grp_t;
  grp_t ent0 = '0;
  grp_t ent1 = '0;
  int   cnt = 0;
  logic mrdy = 1'b1;
  int   mst = 0;
  int   mbu = 0;
  logic en = 1'b0;

  always @(posedge clk) begin : mdl
    automatic int   n  = cnt;
    automatic grp_t e0 = ent0;
    automatic grp_t e1 = ent1;
    automatic logic r  = mrdy;
    automatic int   st = mst;
    automatic int   bu = mbu;
    automatic logic acc;
    if (rst) begin
      n  = 0;
      r  = 1'b1;
      st = 0;
      bu = 0;
      en <= 1'b1;
    end else begin
      if (n > 0 && !out_ready && st < 15) st++;
      if (n == 0 && out_ready && bu < 15) bu++;
      if (flush) begin
        n = 0;
        r = 1'b1;
      end else begin
        acc = in_valid && r;
        if (n > 0 && out_ready) begin
          e0 = e1;
          n--;
        end
        if (acc) begin
          if (n == 0) e0 = {in_lane_valid, in_data};
          else e1 = {in_lane_valid, in_data};
          n++;
        end
        r = (n < 2);
      end
    end
    cnt  <= n;
    ent0 <= e0;
    ent1 <= e1;
    mrdy <= r;
    mst  <= st;
    mbu  <= bu;
  end

  always @(negedge clk) begin : cmp
    automatic grp_t f = (cnt > 0) ? ent0 : '0;
    if (en) begin
      chk("m_in_ready", 64'(in_ready), 64'(mrdy));
      chk("m_out_valid", 64'(out_valid), 64'(cnt > 0));
      chk("m_out_lane_valid", 64'(out_lane_valid), 64'(f[LANES+DW-1:DW]));
      chk("m_out_data", 64'(out_data), 64'(f[DW-1:0]));
`ifdef PIPE_SKID_PERF_EN
      chk("m_stall_cnt", 64'(stall_cnt), 64'(mst));
      chk("m_bubble_cnt", 64'(bubble_cnt), 64'(mbu));
`else
      chk("m_stall_cnt", 64'(stall_cnt), 64'(0));
      chk("m_bubble_cnt", 64'(bubble_cnt), 64'(0));
`endif
    end
  end

  task automatic step(input logic iv, input logic [LANES-1:0] lv,
                      input logic [DW-1:0] d, input logic ordy,
                      input logic fl, input logic rs);
    in_valid      = iv;
    in_lane_valid = lv;
    in_data       = d;
    out_ready     = ordy;
    flush         = fl;
    rst           = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 2'b00, '0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    step(1'b0, 2'b00, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);

    // Streaming A,B,C
    step(1'b1, 2'b11, 32'hA0A1_A2A3, 1'b1, 1'b0, 1'b0);
    chk("str_A", 64'(out_data), 64'hA0A1_A2A3);
    step(1'b1, 2'b11, 32'hB0B1_B2B3, 1'b1, 1'b0, 1'b0);
    chk("str_B", 64'(out_data), 64'hB0B1_B2B3);
    chk("str_rdy_B", 64'(in_ready), 64'd1);
    step(1'b1, 2'b01, 32'hC0C1_C2C3, 1'b1, 1'b0, 1'b0);
    chk("str_C", 64'(out_data), 64'hC0C1_C2C3);
    chk("str_C_lv", 64'(out_lane_valid), 64'd1);
    chk("str_rdy_C", 64'(in_ready), 64'd1);
    idle(1'b1);
    chk("str_drain", 64'(out_valid), 64'd0);

    // Back-pressure into skid
    step(1'b1, 2'b11, 32'h0000_00AA, 1'b0, 1'b0, 1'b0);
    chk("bp_A", 64'(out_data), 64'h0000_00AA);
    chk("bp_rdy1", 64'(in_ready), 64'd1);
    step(1'b1, 2'b11, 32'h0000_00BB, 1'b0, 1'b0, 1'b0);
    chk("bp_hold_A", 64'(out_data), 64'h0000_00AA);
    chk("bp_rdy0", 64'(in_ready), 64'd0);
    step(1'b1, 2'b11, 32'h0000_00CC, 1'b0, 1'b0, 1'b0);
    chk("bp_still_A", 64'(out_data), 64'h0000_00AA);
    idle(1'b1);
    chk("bp_B", 64'(out_data), 64'h0000_00BB);
    chk("bp_rdy_back", 64'(in_ready), 64'd1);
    idle(1'b1);
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush while in SKID with a group offered
    step(1'b1, 2'b11, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 32'h3333_3333, 1'b1, 1'b1, 1'b0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_data", 64'(out_data), 64'd0);
    chk("fl_rdy", 64'(in_ready), 64'd1);
    idle(1'b1);
    chk("fl_gone", 64'(out_valid), 64'd0);

    // Partial lanes and a NOP group
    step(1'b1, 2'b10, 32'h1234_0000, 1'b1, 1'b0, 1'b0);
    chk("ln_lv", 64'(out_lane_valid), 64'h2);
    chk("ln_d1", 64'(out_data[31:16]), 64'h1234);
    step(1'b1, 2'b00, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    chk("nop_valid", 64'(out_valid), 64'd1);
    chk("nop_lv", 64'(out_lane_valid), 64'd0);
    idle(1'b1);

    // Reset in SKID together with flush
    step(1'b1, 2'b11, 32'h5555_5555, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 32'h6666_6666, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 32'h7777_7777, 1'b1, 1'b1, 1'b1);
    chk("rs_valid", 64'(out_valid), 64'd0);
    chk("rs_lv", 64'(out_lane_valid), 64'd0);
    chk("rs_data", 64'(out_data), 64'd0);
    chk("rs_rdy", 64'(in_ready), 64'd1);
    chk("rs_stall", 64'(stall_cnt), 64'd0);
    chk("rs_bubble", 64'(bubble_cnt), 64'd0);

    // Stall saturation then bubble count
    step(1'b1, 2'b11, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) idle(1'b0);
    step(1'b0, 2'b00, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);
`ifdef PIPE_SKID_PERF_EN
    chk("pf_bubble", 64'(bubble_cnt), 64'd3);
`else
    chk("pf_bubble", 64'(bubble_cnt), 64'd0);
`endif
    step(1'b1, 2'b11, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) idle(1'b0);
`ifdef PIPE_SKID_PERF_EN
    chk("pf_stall_sat", 64'(stall_cnt), 64'hF);
`else
    chk("pf_stall_sat", 64'(stall_cnt), 64'd0);
`endif
    step(1'b0, 2'b00, '0, 1'b0, 1'b1, 1'b0);
    chk("pf_flush_keep_valid", 64'(out_valid), 64'd0);

    // Mixed traffic checked by the model only
    for (int i = 0; i < 60; i++) begin
      step(i[0] | i[2], {i[1], ~i[3]}, 32'(i * 32'h0101_0101 + 1),
           ~(i[1] & i[2]), (i % 23) == 22, 1'b0);
    end
    for (int i = 0; i < 3; i++) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
